seg7_scan_driver: RTL and testbench

- Time-multiplexed driver for the board's 4-digit common-anode seven-segment display.
- Owns the digit-select sequencing: a prescaler advances a 2-bit digit index, decodes it to the active-low anode lines AN[3:0] and encodes the selected hex nibble to active-low segments.
- Display data is double-buffered and committed only at frame boundaries, so a digit is never torn mid-scan.
- Sits between user logic (value/load) and the board pins.

---
 rtl/seg7_scan_driver.sv | 147 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed driver for a 4-digit common-anode seven-segment display.
//   A prescaler steps a 2-bit digit index every DIV cycles. The committed
//   nibble of the selected digit is encoded to active-low segments, and the
//   matching anode is pulled low after a short blanking window. New display
//   data is staged in a pending buffer. It is committed only when the index
//   wraps 3->0, so a frame is never torn.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   value       four hex digits, value[3:0] = digit 0 (AN[0])
//   dig_en      per-digit enable (0 = digit dark)
//   dp          per-digit decimal point (1 = lit)
//   load        strobe: capture value/dig_en/dp into the pending buffer
//   pending     pending buffer holds data not yet committed
//   frame_start one-cycle pulse in the first cycle after a 3->0 wrap
//   digit_idx   digit currently being scanned
//   AN          anodes, active-low
//   SEG         segments {g,f,e,d,c,b,a}, active-low
//   DP          decimal point, active-low
module seg7_scan_driver #(
    parameter int DIV          = 100000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  dig_en,
    input  logic [3:0]  dp,
    input  logic        load,
    output logic        pending,
    output logic        frame_start,
    output logic [1:0]  digit_idx,
    output logic [3:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt_q;
    logic [1:0]    idx_q;
    logic          pending_q;
    logic          frame_start_q;
    logic [15:0]   pend_val_q, com_val_q;
    logic [3:0]    pend_en_q,  com_en_q;
    logic [3:0]    pend_dp_q,  com_dp_q;
    logic [3:0]    an_q,  an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q,  dp_d;

    logic          tick;
    logic          wrap;
    logic          lit;
    logic [3:0]    sel_nib;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        tick    = (cnt_q == CW'(DIV - 1));
        wrap    = tick && (idx_q == 2'd3);
        sel_nib = com_val_q[{idx_q, 2'b00} +: 4];
        // Signed compare keeps BLANK_CYCLES == 0 from degenerating to a
        // constant unsigned comparison.
        lit     = (int'(cnt_q) >= BLANK_CYCLES) && com_en_q[idx_q];
        an_d    = lit ? ~(4'b0001 << idx_q) : 4'hF;
        seg_d   = lit ? hex7(sel_nib) : 7'h7F;
        dp_d    = ~(lit && com_dp_q[idx_q]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= '0;
            idx_q         <= 2'd0;
            pending_q     <= 1'b0;
            frame_start_q <= 1'b0;
            pend_val_q    <= '0;
            pend_en_q     <= '0;
            pend_dp_q     <= '0;
            com_val_q     <= '0;
            com_en_q      <= '0;
            com_dp_q      <= '0;
            an_q          <= 4'hF;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
        end else begin
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_start_q <= wrap;

            if (tick) begin
                cnt_q <= '0;
                idx_q <= idx_q + 2'd1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end

            // Commit takes the pending contents from before this edge; a
            // load on the same edge refills pending for the next frame.
            if (wrap && pending_q) begin
                com_val_q <= pend_val_q;
                com_en_q  <= pend_en_q;
                com_dp_q  <= pend_dp_q;
            end

            if (load) begin
                pend_val_q <= value;
                pend_en_q  <= dig_en;
                pend_dp_q  <= dp;
                pending_q  <= 1'b1;
            end else if (wrap) begin
                pending_q  <= 1'b0;
            end
        end
    end

    assign pending     = pending_q;
    assign frame_start = frame_start_q;
    assign digit_idx   = idx_q;
    assign AN          = an_q;
    assign SEG         = seg_q;
    assign DP          = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dig_en = '0;
    logic [3:0]  dp = '0;
    logic        load = 1'b0;
    logic        pending, frame_start, DP;
    logic [1:0]  digit_idx;
    logic [3:0]  AN;
    logic [6:0]  SEG;

    seg7_scan_driver #(.DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
        .clk(clk), .reset(reset), .value(value), .dig_en(dig_en), .dp(dp),
        .load(load), .pending(pending), .frame_start(frame_start),
        .digit_idx(digit_idx), .AN(AN), .SEG(SEG), .DP(DP)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pend;
        logic       fs;
        logic [1:0] idx;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    logic [6:0] hex_tab [16];
    initial hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: m_n counts clock edges since reset left; slot, phase
    // and frame boundaries follow from plain arithmetic on that count.
    int          m_n = 0;
    bit          m_pend = 0;
    logic [15:0] m_pv = '0, m_cv = '0;
    logic [3:0]  m_pe = '0, m_ce = '0, m_pd = '0, m_cd = '0;
    int          m_cnt, m_slot;
    bit          m_lit;
    logic [3:0]  m_nib;
    exp_t        m_e;

    always @(posedge clk) begin
        if (reset) begin
            m_n = 0; m_pend = 0;
            m_pv = '0; m_cv = '0; m_pe = '0; m_ce = '0; m_pd = '0; m_cd = '0;
            m_e = '{pend: 1'b0, fs: 1'b0, idx: 2'd0, an: 4'hF, seg: 7'h7F, dp: 1'b1};
        end else begin
            m_cnt  = m_n % DIV;
            m_slot = (m_n / DIV) % 4;
            m_lit  = m_ce[m_slot] && (m_cnt >= BLANK);
            m_nib  = 4'(m_cv >> (4 * m_slot));
            m_e.an  = m_lit ? (4'hF ^ (4'b0001 << m_slot)) : 4'hF;
            m_e.seg = m_lit ? hex_tab[m_nib] : 7'h7F;
            m_e.dp  = !(m_lit && m_cd[m_slot]);
            m_e.fs  = (m_n % FRAME) == FRAME - 1;
            if (m_e.fs && m_pend) begin
                m_cv = m_pv; m_ce = m_pe; m_cd = m_pd; m_pend = 0;
            end
            if (load) begin
                m_pv = value; m_pe = dig_en; m_pd = dp; m_pend = 1;
            end
            m_n = m_n + 1;
            m_e.pend = m_pend;
            m_e.idx  = 2'((m_n / DIV) % 4);
        end
        sb_q.push_back(m_e);
    end

    exp_t got, want;
    always @(negedge clk) begin
        cyc++;
        if (sb_q.size() > 0) begin
            want = sb_q.pop_front();
            got  = '{pend: pending, fs: frame_start, idx: digit_idx, an: AN, seg: SEG, dp: DP};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL outputs cyc=%0d got pend=%b fs=%b idx=%0d AN=%b SEG=%h DP=%b want pend=%b fs=%b idx=%0d AN=%b SEG=%h DP=%b",
                         cyc, got.pend, got.fs, got.idx, got.an, got.seg, got.dp,
                         want.pend, want.fs, want.idx, want.an, want.seg, want.dp);
            end
            total++;
            if ($countones(~AN) > 1) begin
                bad++;
                $display("FAIL anode_onehot cyc=%0d AN=%b want at most one low", cyc, AN);
            end
        end
    end

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] e, input logic [3:0] d);
        value = v; dig_en = e; dp = d; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_phase(input int ph);
        int k;
        k = 0;
        while ((m_n % FRAME) != ph && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            total++; bad++;
            $display("FAIL wait_phase got phase=%0d want %0d", m_n % FRAME, ph);
        end
    endtask

    initial begin
        step(3);
        reset = 1'b0;

        do_load(16'h1234, 4'b1111, 4'b0000);
        step(2 * FRAME);

        do_load(16'hFEDC, 4'b1111, 4'b0101); step(2 * FRAME);
        do_load(16'hBA98, 4'b1111, 4'b0101); step(2 * FRAME);
        do_load(16'h7654, 4'b1111, 4'b0101); step(2 * FRAME);
        do_load(16'h3210, 4'b1111, 4'b0101); step(2 * FRAME);

        do_load(16'h5A3C, 4'b1010, 4'b1111); step(2 * FRAME);

        wait_phase(8);
        do_load(16'hAAAA, 4'b1111, 4'b0000);
        step(3);
        do_load(16'hBBBB, 4'b1111, 4'b0000);
        wait_phase(FRAME - 1);
        do_load(16'hCCCC, 4'b1111, 4'b0011);
        step(3 * FRAME);

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 9) == 0)
                do_load(16'($urandom), 4'($urandom), 4'($urandom));
            else
                step(1);
        end
        step(2 * FRAME);

        do_load(16'h9ABC, 4'b1111, 4'b1111);
        step(2 * FRAME);
        wait_phase(16);
        do_load(16'h0F0F, 4'b1111, 4'b0000);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(2 * FRAME);

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
